dds_phase_acc: RTL and testbench



---
 rtl/dds_phase_acc.sv | 173 +++++++++++++++++
 tb/tb_dds_phase_acc.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator: integrates a tuning word, offsets the truncated phase and registers the ROM address.
// Optional macro DDS_PHASE_SYNC_UPDATE_EN defers RUN-time configuration changes to the accumulator wrap.
module dds_phase_acc #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ACC_W-1:0]  cfg_fword,
  input  logic [ADDR_W-1:0] cfg_pword,
  input  logic [1:0]        cfg_wave,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [1:0]        wave_sel,
  output logic              addr_valid,
  output logic              wrap
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [ACC_W:0]    sum_p0;
  logic [ACC_W-1:0]  fword_a, fword_a_nxt;
  logic [ADDR_W-1:0] pword_a, pword_a_nxt;
  logic [1:0]        wave_a, wave_a_nxt;
  logic              wrap_nxt;
  logic              cfg_fire;
  logic [ADDR_W-1:0] phase_p0;

  // Phase offset wraps around the ROM; no saturation by design.
  function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
    return a + b;
  endfunction

`ifdef DDS_PHASE_SYNC_UPDATE_EN
  logic [ACC_W-1:0]  fword_s, fword_s_nxt;
  logic [ADDR_W-1:0] pword_s, pword_s_nxt;
  logic [1:0]        wave_s, wave_s_nxt;

  assign cfg_ready = (state != PEND);
`else
  assign cfg_ready = 1'b1;
`endif

  assign cfg_fire = cfg_valid && cfg_ready;
  assign sum_p0   = {1'b0, acc} + {1'b0, fword_a};
  assign phase_p0 = acc[ACC_W-1 -: ADDR_W];

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    fword_a_nxt = fword_a;
    pword_a_nxt = pword_a;
    wave_a_nxt  = wave_a;
    wrap_nxt    = 1'b0;
`ifdef DDS_PHASE_SYNC_UPDATE_EN
    fword_s_nxt = fword_s;
    pword_s_nxt = pword_s;
    wave_s_nxt  = wave_s;
`endif
    if (clr) begin
      acc_nxt = '0;
`ifdef DDS_PHASE_SYNC_UPDATE_EN
      if (state == PEND) begin
        fword_a_nxt = fword_s;
        pword_a_nxt = pword_s;
        wave_a_nxt  = wave_s;
      end
`endif
      // A word offered alongside clr overrides any pending shadow.
      if (cfg_fire) begin
        fword_a_nxt = cfg_fword;
        pword_a_nxt = cfg_pword;
        wave_a_nxt  = cfg_wave;
      end
      state_nxt = en ? RUN : IDLE;
    end else begin
      if (state != IDLE && en) begin
        acc_nxt  = sum_p0[ACC_W-1:0];
        wrap_nxt = sum_p0[ACC_W];
      end
      case (state)
        IDLE: begin
          if (cfg_fire) begin
            fword_a_nxt = cfg_fword;
            pword_a_nxt = cfg_pword;
            wave_a_nxt  = cfg_wave;
          end
          if (en) state_nxt = RUN;
        end
        RUN: begin
          if (!en) state_nxt = IDLE;
`ifdef DDS_PHASE_SYNC_UPDATE_EN
          if (cfg_fire && en) begin
            fword_s_nxt = cfg_fword;
            pword_s_nxt = cfg_pword;
            wave_s_nxt  = cfg_wave;
            state_nxt   = PEND;
          end else if (cfg_fire) begin
`else
          if (cfg_fire) begin
`endif
            fword_a_nxt = cfg_fword;
            pword_a_nxt = cfg_pword;
            wave_a_nxt  = cfg_wave;
          end
        end
`ifdef DDS_PHASE_SYNC_UPDATE_EN
        PEND: begin
          if (!en || sum_p0[ACC_W]) begin
            fword_a_nxt = fword_s;
            pword_a_nxt = pword_s;
            wave_a_nxt  = wave_s;
            state_nxt   = en ? RUN : IDLE;
          end
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stage p0: accumulator and configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      fword_a <= '0;
      pword_a <= '0;
      wave_a  <= '0;
      wrap    <= 1'b0;
`ifdef DDS_PHASE_SYNC_UPDATE_EN
      fword_s <= '0;
      pword_s <= '0;
      wave_s  <= '0;
`endif
    end else begin
      acc     <= acc_nxt;
      fword_a <= fword_a_nxt;
      pword_a <= pword_a_nxt;
      wave_a  <= wave_a_nxt;
      wrap    <= wrap_nxt;
`ifdef DDS_PHASE_SYNC_UPDATE_EN
      fword_s <= fword_s_nxt;
      pword_s <= pword_s_nxt;
      wave_s  <= wave_s_nxt;
`endif
    end
  end

  // Stage p1: registered ROM address, one cycle behind acc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr   <= '0;
      wave_sel   <= '0;
      addr_valid <= 1'b0;
    end else begin
      rom_addr   <= addr_add(phase_p0, pword_a);
      wave_sel   <= wave_a;
      addr_valid <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_dds_phase_acc.sv
// Directed bench for dds_phase_acc: table of single-point address vectors plus hand-written sequences.
module tb_dds_phase_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_fword = '0;
  logic [8:0]  cfg_pword = '0;
  logic [1:0]  cfg_wave = '0;
  logic [8:0]  rom_addr;
  logic [1:0]  wave_sel;
  logic        addr_valid;
  logic        wrap;

  int errors = 0;
  int checks = 0;

  dds_phase_acc #(.ACC_W(32), .ADDR_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_fword(cfg_fword), .cfg_pword(cfg_pword), .cfg_wave(cfg_wave),
    .rom_addr(rom_addr), .wave_sel(wave_sel), .addr_valid(addr_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] fword;
    logic [8:0]  pword;
    logic [1:0]  wave;
    int          m;
    logic [8:0]  exp_addr;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    en = 1'b0; clr = 1'b0; cfg_valid = 1'b0;
    cfg_fword = '0; cfg_pword = '0; cfg_wave = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // Loads the active set from IDLE and enables; the returned point is just after edge E1.
  task automatic setup(input logic [31:0] f, input logic [8:0] p, input logic [1:0] w);
    cfg_fword = f; cfg_pword = p; cfg_wave = w;
    cfg_valid = 1'b1; en = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_wave_sel"}, wave_sel, 0);
    chk({tag, "_addr_valid"}, addr_valid, 0);
    chk({tag, "_wrap"}, wrap, 0);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
  endtask

  initial begin
    int n;
    logic bad;

    // After E(1+m): rom_addr = phase((m-1)*fword) + pword mod 512
    vecs[0] = '{32'h0080_0000, 9'h000, 2'd0,   1, 9'd0};
    vecs[1] = '{32'h0080_0000, 9'h100, 2'd0, 301, 9'd44};
    vecs[2] = '{32'h0080_0000, 9'h000, 2'd1, 301, 9'd300};
    vecs[3] = '{32'h0100_0000, 9'h005, 2'd2,  11, 9'd25};
    vecs[4] = '{32'h0040_0000, 9'h000, 2'd3,  11, 9'd5};
    vecs[5] = '{32'hFFFF_FFFF, 9'h000, 2'd2,   3, 9'd511};
    vecs[6] = '{32'h0000_0000, 9'h1FF, 2'd3,  10, 9'd511};
    vecs[7] = '{32'h0080_0000, 9'h1FF, 2'd1,   3, 9'd1};

    #2;
    chk_reset_outputs("reset");
    do_reset();

    for (int i = 0; i < 8; i++) begin
      do_reset();
      setup(vecs[i].fword, vecs[i].pword, vecs[i].wave);
      repeat (vecs[i].m) tick();
      chk($sformatf("vec%0d_rom_addr", i), rom_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_wave_sel", i), wave_sel, vecs[i].wave);
      chk($sformatf("vec%0d_addr_valid", i), addr_valid, 1);
    end

    // Full sweep: addresses 0..511,0 with a single wrap one cycle before address 0
    do_reset();
    setup(32'h0080_0000, 9'h000, 2'd0);
    for (int k = 2; k <= 514; k++) begin
      tick();
      chk($sformatf("sweep_addr_e%0d", k), rom_addr, (k - 2) % 512);
      chk($sformatf("sweep_wrap_e%0d", k), wrap, (k == 513) ? 1 : 0);
    end

    // Mid-cycle frequency change
    do_reset();
    setup(32'h0080_0000, 9'h000, 2'd0);
    repeat (100) tick();
    chk("chg_pre_addr", rom_addr, 99);
    chk("chg_pre_ready", cfg_ready, 1);
    cfg_fword = 32'h0100_0000; cfg_pword = '0; cfg_wave = '0; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("chg_hs_addr", rom_addr, 100);
`ifdef DDS_PHASE_SYNC_UPDATE_EN
    n = 0; bad = 1'b0;
    while (!wrap && n < 600) begin
      if (cfg_ready !== 1'b0) bad = 1'b1;
      tick();
      n++;
    end
    chk("sync_ready_low_until_wrap", bad, 0);
    chk("sync_cycles_to_wrap", n, 411);
    chk("sync_wrap_addr", rom_addr, 511);
    chk("sync_ready_after_wrap", cfg_ready, 1);
    tick(); chk("sync_step_a0", rom_addr, 0);
    tick(); chk("sync_step_a1", rom_addr, 2);
    tick(); chk("sync_step_a2", rom_addr, 4);

    // en=0 in PEND applies the shadow immediately and returns to IDLE
    do_reset();
    setup(32'h0080_0000, 9'h000, 2'd0);
    repeat (5) tick();
    cfg_fword = 32'h0100_0000; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("pend_ready_low", cfg_ready, 0);
    chk("pend_addr", rom_addr, 5);
    en = 1'b0;
    tick();
    chk("pend_en0_ready", cfg_ready, 1);
    chk("pend_en0_addr", rom_addr, 6);
    tick();
    chk("pend_en0_valid", addr_valid, 0);
    en = 1'b1;
    tick(); tick(); tick();
    chk("pend_resume_a0", rom_addr, 8);
    tick();
    chk("pend_resume_a1", rom_addr, 10);
`else
    n = 0;
    tick(); chk("imm_addr_a1", rom_addr, 101); chk("imm_ready_a1", cfg_ready, 1);
    tick(); chk("imm_addr_a2", rom_addr, 103); chk("imm_ready_a2", cfg_ready, 1);
    tick(); chk("imm_addr_a3", rom_addr, 105);
`endif

    // clr suppresses a wrap that would otherwise occur; clr with cfg loads active directly
    do_reset();
    setup(32'h8000_0000, 9'h010, 2'd1);
    tick(); chk("clr_e2_addr", rom_addr, 16);
    tick(); chk("clr_e3_wrap", wrap, 1); chk("clr_e3_addr", rom_addr, 272);
    tick(); chk("clr_e4_wrap", wrap, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_e5_wrap", wrap, 0);
    chk("clr_e5_addr", rom_addr, 272);
    tick(); chk("clr_e6_addr", rom_addr, 16); chk("clr_e6_wrap", wrap, 0);
    tick(); chk("clr_e7_wrap", wrap, 1);
    clr = 1'b1;
    cfg_fword = 32'h0080_0000; cfg_pword = 9'h020; cfg_wave = 2'd2; cfg_valid = 1'b1;
    tick();
    clr = 1'b0; cfg_valid = 1'b0;
    chk("clrcfg_e8_wrap", wrap, 0);
    chk("clrcfg_e8_addr", rom_addr, 16);
    tick(); chk("clrcfg_e9_addr", rom_addr, 32); chk("clrcfg_e9_wave", wave_sel, 2);
    tick(); chk("clrcfg_e10_addr", rom_addr, 33);
    tick(); chk("clrcfg_e11_addr", rom_addr, 34);

    // Asynchronous reset while a change is pending discards the shadow
    do_reset();
    setup(32'h0080_0000, 9'h000, 2'd0);
    repeat (5) tick();
    cfg_fword = 32'h0100_0000; cfg_pword = 9'h055; cfg_wave = 2'd3; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    repeat (3) tick();
`ifdef DDS_PHASE_SYNC_UPDATE_EN
    chk("arst_pre_ready", cfg_ready, 0);
`endif
    #3 rst_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    #2 rst_n = 1'b1;
    en = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (wrap !== 1'b0 || rom_addr !== 9'd0) bad = 1'b1;
    end
    chk("arst_frozen", bad, 0);
    chk("arst_rom_addr", rom_addr, 0);
    chk("arst_wave_sel", wave_sel, 0);
    chk("arst_addr_valid", addr_valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
